// File: rtl/xil_mem_dp_be.sv
// True dual-port word memory with per-byte write enables, write-first reads,
// same-address collision merging and an optional power-up zero-fill sequencer.
module xil_mem_dp_be #(
  parameter int ADR_W   = 10,
  parameter int BYTES   = 2,
  parameter int OUT_REG = 0,
  parameter int CLEAR   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 o_ready,
  input  logic                 i_en0,
  input  logic                 i_en1,
  input  logic [BYTES-1:0]     i_wen0,
  input  logic [BYTES-1:0]     i_wen1,
  input  logic [ADR_W-1:0]     i_adr0,
  input  logic [ADR_W-1:0]     i_adr1,
  input  logic [8*BYTES-1:0]   i_wdata0,
  input  logic [8*BYTES-1:0]   i_wdata1,
  output logic [8*BYTES-1:0]   o_rdata0,
  output logic [8*BYTES-1:0]   o_rdata1,
  output logic                 o_valid0,
  output logic                 o_valid1
);

  localparam int W     = 8 * BYTES;
  localparam int DEPTH = 1 << ADR_W;

  localparam logic [0:0] ST_CLR = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;
  localparam logic [0:0] ST_RST = (CLEAR != 0) ? ST_CLR : ST_RUN;

  logic [0:0]       state_q, state_d;
  logic [ADR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             ready_q, ready_d;

  logic [W-1:0]     mem [DEPTH];

  logic [1:0]                acc, wr;
  logic                      same_adr;
  logic [1:0][ADR_W-1:0]     adr;
  logic [1:0][BYTES-1:0]     wen;
  logic [1:0][W-1:0]         wdat, mrg;

  logic [1:0]                v1_q, v1_d;
  logic [1:0][W-1:0]         d1_q, d1_d;
  logic [1:0]                v_out;
  logic [1:0][W-1:0]         d_out;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLR) begin
      // Stop on the last address instead of wrapping the counter.
      if (&clr_cnt_q) state_d = ST_RUN;
      else            clr_cnt_d = clr_cnt_q + 1'b1;
    end
    ready_d = (state_d == ST_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RST;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  assign o_ready = ready_q;

  // Both ports see the same merged word on an address collision; port 0 owns
  // the lanes both ports enable, so the two write values are always identical.
  always_comb begin
    adr[0]   = i_adr0;
    adr[1]   = i_adr1;
    wen[0]   = i_wen0;
    wen[1]   = i_wen1;
    wdat[0]  = i_wdata0;
    wdat[1]  = i_wdata1;
    acc[0]   = i_en0 & ready_q;
    acc[1]   = i_en1 & ready_q;
    same_adr = (i_adr0 == i_adr1);
    for (int p = 0; p < 2; p++) begin
      wr[p]  = acc[p] & (|wen[p]);
      mrg[p] = mem[adr[p]];
      for (int b = 0; b < BYTES; b++) begin
        if (acc[0] && wen[0][b] && (p == 0 || same_adr))
          mrg[p][8*b +: 8] = wdat[0][8*b +: 8];
        else if (acc[1] && wen[1][b] && (p == 1 || same_adr))
          mrg[p][8*b +: 8] = wdat[1][8*b +: 8];
      end
    end
  end

  // NOTE: the array has no reset so it maps onto block RAM; zeroing is done by
  // the clear sequencer instead.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLR) begin
      mem[clr_cnt_q] <= '0;
    end else begin
      for (int p = 0; p < 2; p++)
        if (wr[p]) mem[adr[p]] <= mrg[p];
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      v1_d[p] = acc[p];
      d1_d[p] = acc[p] ? mrg[p] : d1_q[p];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= '0;
      d1_q <= '0;
    end else begin
      v1_q <= v1_d;
      d1_q <= d1_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [1:0]        v2_q, v2_d;
      logic [1:0][W-1:0] d2_q, d2_d;

      always_comb begin
        for (int p = 0; p < 2; p++) begin
          v2_d[p] = v1_q[p];
          d2_d[p] = v1_q[p] ? d1_q[p] : d2_q[p];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v2_q <= '0;
          d2_q <= '0;
        end else begin
          v2_q <= v2_d;
          d2_q <= d2_d;
        end
      end

      assign v_out = v2_q;
      assign d_out = d2_q;
    end else begin : g_noreg
      assign v_out = v1_q;
      assign d_out = d1_q;
    end
  endgenerate

  assign o_valid0 = v_out[0];
  assign o_valid1 = v_out[1];
  assign o_rdata0 = d_out[0];
  assign o_rdata1 = d_out[1];

endmodule
